// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and misalignment rule for the load/store unit.
// Sizes 011, 110 and 111 have no encoding of their own and decode as word accesses.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  // size[1] set means word (including the illegal encodings); otherwise size[0] means halfword.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (size[1]) begin
      mis = (off != 2'b00);
    end else if (size[0]) begin
      mis = off[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Selects the addressed byte/halfword of a memory word and sign- or zero-extends it.
// Purely combinational; unknown sizes return the full word.
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rd_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rd_i[7:0];
      2'd1:    byte_sel = rd_i[15:8];
      2'd2:    byte_sel = rd_i[23:16];
      default: byte_sel = rd_i[31:24];
    endcase
    half_sel = off_i[1] ? rd_i[31:16] : rd_i[15:0];

    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'h000000, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'h0000, half_sel};
      default: data_o = rd_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: 2-cycle minimum access (request + completion), stalls the core while memory is not ready.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word requests in IDLE without stalling.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        reject;
  logic        accept;
  logic [31:0] fmt_dat;

`ifdef LSU_MISALIGN_CHECK_EN
  assign reject = (state_q == IDLE) && core_req_i && is_misaligned(core_size_i, core_addr_i[1:0]);
`else
  assign reject = 1'b0;
`endif

  assign accept     = (state_q == IDLE) && core_req_i && !reject;
  assign misalign_o = reject && rst_ni;

  assign mem_we_o   = core_we_i;
  assign mem_addr_o = core_addr_i;

  always_comb begin
    mem_be_o = 4'b0000;
    mem_wd_o = core_wd_i;
    case (core_size_i)
      LDST_B, LDST_BU: begin
        mem_be_o = 4'b0001 << core_addr_i[1:0];
        mem_wd_o = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
        mem_wd_o = {2{core_wd_i[15:0]}};
      end
      default: mem_be_o = 4'b1111;
    endcase
    if (!core_we_i) begin
      mem_be_o = 4'b0000;
    end
  end

  lsu_load_fmt u_load_fmt (
    .rd_i   (mem_rd_i),
    .size_i (size_q),
    .off_i  (off_q),
    .data_o (fmt_dat)
  );

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    mem_req_o    = 1'b0;
    core_stall_o = 1'b0;
    core_rd_o    = 32'h0;
    case (state_q)
      IDLE: begin
        mem_req_o    = accept;
        core_stall_o = accept;
        if (accept) begin
          state_d = WAIT;
          off_d   = core_addr_i[1:0];
          size_d  = core_size_i;
        end
      end
      WAIT: begin
        // Completes on ready even if the core has dropped its request.
        mem_req_o    = 1'b1;
        core_stall_o = !mem_ready_i;
        if (mem_ready_i) begin
          state_d   = IDLE;
          core_rd_o = fmt_dat;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_ni) begin
      core_stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      size_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for lsu against a byte-level arithmetic reference model.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int checks = 0;
  int errors = 0;

  lsu dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misalign_o   (misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: access width in bytes from funct3; illegal sizes are words.
  function automatic int nbytes(input logic [2:0] size);
    if (size == 3'b000 || size == 3'b100) return 1;
    if (size == 3'b001 || size == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] size, input logic [31:0] addr);
    int n, base;
    if (!we) return 4'b0000;
    n = nbytes(size);
    base = (n == 4) ? 0 : (n == 2) ? int'(addr % 4) / 2 * 2 : int'(addr % 4);
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] size, input logic [31:0] wd);
    int n;
    n = nbytes(size);
    if (n == 1) return (wd % 256) * 32'h01010101;
    if (n == 2) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] rd);
    int n, sh;
    logic [31:0] mask, v;
    n = nbytes(size);
    if (n == 4) return rd;
    sh = (n == 2) ? (int'(addr % 4) / 2) * 16 : int'(addr % 4) * 8;
    mask = (32'h1 << (8 * n)) - 1;
    v = (rd >> sh) & mask;
    if (size < 3'b100 && v >= (mask + 1) / 2) v = v | ~mask;
    return v;
  endfunction

  function automatic logic exp_mis(input logic [2:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
    int n;
    n = nbytes(size);
    return (n > 1) && (addr % n != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One access: request cycle, 'waits' not-ready cycles, then the ready cycle.
  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int waits,
                            input bit drop_req);
    logic mis;
    logic [31:0] exp_rd;
    mis = exp_mis(size, addr);
    exp_rd = exp_ld(size, addr, rd);
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = we; core_size_i = size; core_addr_i = addr; core_wd_i = wd;
    mem_rd_i = $urandom; mem_ready_i = $urandom_range(0, 1) != 0;
    #3;
    checks++; if (misalign_o !== mis) begin errors++; $display("FAIL req_misalign got %b exp %b", misalign_o, mis); end
    checks++; if (mem_req_o !== !mis) begin errors++; $display("FAIL req_mem_req got %b exp %b", mem_req_o, !mis); end
    checks++; if (core_stall_o !== !mis) begin errors++; $display("FAIL req_stall got %b exp %b", core_stall_o, !mis); end
    checks++; if (mem_be_o !== exp_be(we, size, addr)) begin errors++; $display("FAIL req_be got %b exp %b", mem_be_o, exp_be(we, size, addr)); end
    if (we) begin
      checks++; if (mem_wd_o !== exp_wd(size, wd)) begin errors++; $display("FAIL req_wd got %h exp %h", mem_wd_o, exp_wd(size, wd)); end
    end
    checks++; if (mem_addr_o !== addr || mem_we_o !== we) begin errors++; $display("FAIL req_addr_we got %h/%b exp %h/%b", mem_addr_o, mem_we_o, addr, we); end
    checks++; if (core_rd_o !== 32'h0) begin errors++; $display("FAIL req_rd got %h exp 0", core_rd_o); end
    if (mis) return;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0; mem_rd_i = $urandom;
      #3;
      checks++; if (core_stall_o !== 1'b1 || mem_req_o !== 1'b1) begin errors++; $display("FAIL wait_stall_req got %b/%b exp 1/1", core_stall_o, mem_req_o); end
      checks++; if (core_rd_o !== 32'h0) begin errors++; $display("FAIL wait_rd got %h exp 0", core_rd_o); end
    end
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1; mem_rd_i = rd;
    if (drop_req) core_req_i = 1'b0;
    #3;
    checks++; if (core_stall_o !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL done_stall_req got %b/%b exp 0/1", core_stall_o, mem_req_o); end
    if (!we) begin
      checks++; if (core_rd_o !== exp_rd) begin errors++; $display("FAIL done_rd size=%b addr=%h got %h exp %h", size, addr, core_rd_o, exp_rd); end
    end
  endtask

  task automatic test_idle_after;
    @(posedge clk_i); #1;
    core_req_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'hDEADBEEF;
    #3;
    checks++; if (core_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL idle_stall_req got %b/%b exp 0/0", core_stall_o, mem_req_o); end
    checks++; if (core_rd_o !== 32'h0) begin errors++; $display("FAIL idle_rd got %h exp 0", core_rd_o); end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010;
    core_addr_i = 32'h2; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #4;
    checks++; if (core_stall_o !== 1'b0 || misalign_o !== 1'b0) begin errors++; $display("FAIL reset_stall_mis got %b/%b exp 0/0", core_stall_o, misalign_o); end
    checks++; if (core_rd_o !== 32'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", core_rd_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1; core_req_i = 1'b0;
    #3;
    checks++; if (mem_req_o !== 1'b0 || core_stall_o !== 1'b0) begin errors++; $display("FAIL reset_idle got %b/%b exp 0/0", mem_req_o, core_stall_o); end
  endtask

  task automatic test_store;
    run_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1'b0);
    run_access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 1, 1'b0);
    run_access(1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    run_access(1'b1, 3'b111, 32'h0000_3004, 32'h0102_0304, 32'h0, 0, 1'b0);
    test_idle_after();
  endtask

  task automatic test_load;
    run_access(1'b0, 3'b000, 32'h0000_4002, 32'h0, 32'h12F4_5678, 0, 1'b0);
    run_access(1'b0, 3'b100, 32'h0000_4002, 32'h0, 32'h12F4_5678, 0, 1'b0);
    run_access(1'b0, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_1234, 0, 1'b0);
    run_access(1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'h8001_1234, 0, 1'b0);
    run_access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h8001_1234, 0, 1'b0);
    run_access(1'b0, 3'b110, 32'h0000_4000, 32'h0, 32'h8765_4321, 0, 1'b0);
    test_idle_after();
  endtask

  task automatic test_wait_states;
    run_access(1'b0, 3'b001, 32'h0000_5000, 32'h0, 32'h0000_F00F, 3, 1'b0);
    test_idle_after();
  endtask

  task automatic test_req_drop;
    run_access(1'b0, 3'b000, 32'h0000_6001, 32'h0, 32'h0000_8000, 2, 1'b1);
    #1;
    checks++; if (core_stall_o !== 1'b0) begin errors++; $display("FAIL drop_stall got %b exp 0", core_stall_o); end
    test_idle_after();
  endtask

  task automatic test_reset_in_wait;
    @(posedge clk_i); #1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h7000; mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #3;
    checks++; if (core_stall_o !== 1'b0 || misalign_o !== 1'b0) begin errors++; $display("FAIL rstwait_during got %b/%b exp 0/0", core_stall_o, misalign_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1; core_req_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'hFFFF_FFFF;
    #3;
    checks++; if (core_stall_o !== 1'b0 || core_rd_o !== 32'h0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL rstwait_idle got %b/%h/%b exp 0/0/0", core_stall_o, core_rd_o, mem_req_o); end
    run_access(1'b0, 3'b000, 32'h0000_7003, 32'h0, 32'h7F00_0000, 0, 1'b0);
    test_idle_after();
  endtask

  task automatic test_misalign;
    run_access(1'b0, 3'b010, 32'h0000_8002, 32'h0, 32'hA1B2_C3D4, 0, 1'b0);
    run_access(1'b0, 3'b001, 32'h0000_8001, 32'h0, 32'hA1B2_C3D4, 0, 1'b0);
    run_access(1'b1, 3'b001, 32'h0000_8003, 32'h0000_5A5A, 32'h0, 0, 1'b0);
    test_idle_after();
  endtask

  task automatic test_random;
    for (int n = 0; n < 200; n++) begin
      run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end
    test_idle_after();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wait_states();
    test_req_drop();
    test_reset_in_wait();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
